fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction decoder. Generates sequential PCs, issues requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents one instruction plus its PC per cycle to decode under a valid/ready handshake. Branch and jump redirects from downstream flush the buffer and discard in-flight stale responses.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, canonical NOP, fetch FSM states.
// No ports; imported by the fetch slice.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: imem request/response, redirect and decode handshake.
// master = fetch side, slave = environment (memory + decode).
interface fetch_unit_if;
  import riscv_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, instr_pc,
    output fetch_fault,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, instr_pc,
    input  fetch_fault,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instr}; push/pop/flush.
// Ports: push/din, pop/dout (head), flush, count, full, empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd;
  logic [PW-1:0]    wr;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + PW'(1);
      if (do_pop)  rd <= rd + PW'(1);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, credit-limited imem requests,
// in-order response buffering, redirect flush with stale-kill count.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   kill_q;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [PW-1:0]   pq_rd;
  logic [PW-1:0]   pq_wr;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [63:0]     fifo_dout;

  logic            have;
  logic            pop;
  logic            push;
  logic            redir;
  logic            redir_ok;
  logic            credit;
  logic            req_hs;
  logic            resp_acc;
  logic [CW-1:0]   outst_d;

  assign redir    = bus.redirect_valid
                 && state_q != BOOT;
  assign redir_ok = redir
                 && bus.redirect_pc[1:0] == 2'b00;

  assign have = !fifo_empty;
  assign pop  = have && bus.instr_ready;

  // A slot being popped this cycle is free before any new
  // response can land, so it counts as credit; this keeps
  // one instruction per cycle at DEPTH 2.
  assign credit = ({1'b0, outst_q} + {1'b0, fifo_count})
                < ((CW+1)'(DEPTH) + (CW+1)'(pop));

  assign bus.imem_req_valid = state_q == RUN && credit;
  assign bus.imem_req_addr  = pc_q;

  assign req_hs   = bus.imem_req_valid
                 && bus.imem_req_ready;
  assign resp_acc = bus.imem_resp_valid
                 && outst_q != '0;
  assign push     = resp_acc && kill_q == '0;
  assign outst_d  = outst_q + CW'(req_hs)
                            - CW'(resp_acc);

  assign bus.instr_valid = have;
  assign bus.instr       = have ? fifo_dout[31:0]
                                : NOP_INSTR;
  assign bus.instr_pc    = have ? fifo_dout[63:32]
                                : '0;
  assign bus.fetch_fault = state_q == FAULT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:       state_d = RUN;
      RUN, FAULT: begin
        if (redir) state_d = redir_ok ? RUN : FAULT;
      end
      default:    state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      kill_q  <= '0;
      pq_rd   <= '0;
      pq_wr   <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (req_hs)   pq_wr <= pq_wr + PW'(1);
      if (resp_acc) pq_rd <= pq_rd + PW'(1);
      // Everything still in flight after a redirect is stale.
      if (redir)
        kill_q <= outst_d;
      else if (resp_acc && kill_q != '0)
        kill_q <= kill_q - CW'(1);
      if (redir_ok)
        pc_q <= bus.redirect_pc;
      else if (req_hs)
        pc_q <= pc_q + 32'd4;
    end
  end

  // PC of each request, consumed in response order
  // (killed responses pop too, keeping alignment).
  always_ff @(posedge clk) begin
    if (req_hs) pcq[pq_wr] <= pc_q;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   ({pcq[pq_rd], bus.imem_resp_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop)
  );
endmodule
